// File: rtl/bin_to_bcd_formatter_if.sv
// Request and display bus of the binary-to-BCD display formatter.
// The master side supplies the binary count and decimal-point selection;
// the slave side returns the registered digits, decimal points and status.
interface bin_to_bcd_formatter_if;
  logic [26:0] bin_in;
  logic        bin_valid;
  logic [2:0]  dp_sel;
  logic        dp_en;
  logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
  logic        dp0, dp1, dp2, dp3, dp4, dp5, dp6, dp7;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (
    output bin_in, bin_valid, dp_sel, dp_en,
    input  digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7,
    input  dp0, dp1, dp2, dp3, dp4, dp5, dp6, dp7,
    input  busy, done, ovf
  );

  modport slave (
    input  bin_in, bin_valid, dp_sel, dp_en,
    output digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7,
    output dp0, dp1, dp2, dp3, dp4, dp5, dp6, dp7,
    output busy, done, ovf
  );
endinterface

// File: rtl/bin_to_bcd_formatter.sv
// Sequential double-dabble converter turning a 27-bit count into eight BCD
// display digits with optional leading-zero blanking and one decimal point.
// A conversion takes 27 shift cycles plus one update cycle; the display
// outputs only change on the update edge, so no partial result is visible.
module bin_to_bcd_formatter #(
  parameter logic [3:0] BLANK_CODE = 4'hF,
  parameter bit         LZ_BLANK   = 1'b1
) (
  input logic clk,
  input logic rst,
  bin_to_bcd_formatter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  localparam logic [26:0] MAX_VALUE = 27'd99_999_999;

  state_t      state;
  logic [31:0] bcd;
  logic [26:0] bin;
  logic [4:0]  count;
  logic [2:0]  dp_sel_q;
  logic        dp_en_q;
  logic        ovf_q;

  logic [31:0] bcd_adj;
  logic [3:0]  disp [8];
  logic [7:0]  dp_next;
  logic        all_zero;

  // Double-dabble correction: nibbles of 5 or more get +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Display formatting: blank leading zeros down to the lit decimal point.
  always_comb begin
    all_zero = 1'b1;
    disp     = '{default: 4'd0};
    dp_next  = '0;
    for (int k = 7; k >= 0; k--) begin
      all_zero   = all_zero && (bcd[4*k +: 4] == 4'd0);
      disp[k]    = bcd[4*k +: 4];
      dp_next[k] = dp_en_q && (dp_sel_q == 3'(k));
      if (LZ_BLANK && (k != 0) && all_zero && (!dp_en_q || (3'(k) > dp_sel_q))) begin
        disp[k] = BLANK_CODE;
      end
    end
  end

  // Control FSM with the datapath registers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bcd        <= '0;
      bin        <= '0;
      count      <= '0;
      dp_sel_q   <= '0;
      dp_en_q    <= 1'b0;
      ovf_q      <= 1'b0;
      bus.digit0 <= '0; bus.digit1 <= '0; bus.digit2 <= '0; bus.digit3 <= '0;
      bus.digit4 <= '0; bus.digit5 <= '0; bus.digit6 <= '0; bus.digit7 <= '0;
      bus.dp0    <= 1'b0; bus.dp1 <= 1'b0; bus.dp2 <= 1'b0; bus.dp3 <= 1'b0;
      bus.dp4    <= 1'b0; bus.dp5 <= 1'b0; bus.dp6 <= 1'b0; bus.dp7 <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bin_valid) begin
            if (bus.bin_in > MAX_VALUE) begin
              bin   <= MAX_VALUE;
              ovf_q <= 1'b1;
            end else begin
              bin   <= bus.bin_in;
              ovf_q <= 1'b0;
            end
            dp_sel_q <= bus.dp_sel;
            dp_en_q  <= bus.dp_en;
            bcd      <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          count      <= count + 5'd1;
          if (count == 5'd26) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          bus.digit0 <= disp[0]; bus.digit1 <= disp[1];
          bus.digit2 <= disp[2]; bus.digit3 <= disp[3];
          bus.digit4 <= disp[4]; bus.digit5 <= disp[5];
          bus.digit6 <= disp[6]; bus.digit7 <= disp[7];
          bus.dp0    <= dp_next[0]; bus.dp1 <= dp_next[1];
          bus.dp2    <= dp_next[2]; bus.dp3 <= dp_next[3];
          bus.dp4    <= dp_next[4]; bus.dp5 <= dp_next[5];
          bus.dp6    <= dp_next[6]; bus.dp7 <= dp_next[7];
          bus.ovf    <= ovf_q;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd_formatter.md
BIN_TO_BCD_FORMATTER -- requirements
Module: bin_to_bcd_formatter

Interface
REQ-001 SHALL provide parameter BLANK_CODE, default 4'hF: digit code driven for blanked leading-zero positions.
REQ-002 SHALL provide parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-003 SHALL have port clk  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bin_in  input  27  unsigned binary count to convert.
REQ-006 SHALL have port bin_valid  input  1  request strobe; bin_in, dp_sel and dp_en are sampled when it is high in IDLE.
REQ-007 SHALL have port dp_sel  input  3  index (0-7) of the digit whose decimal point is lit.
REQ-008 SHALL have port dp_en  input  1  enables the decimal point given by dp_sel.
REQ-009 SHALL have ports digit0..digit7  output  4 each  registered BCD digits; digit0 is least significant, digit7 most significant.
REQ-010 SHALL have ports dp0..dp7  output  1 each  registered decimal-point flags.
REQ-011 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when new digits appear on the outputs.
REQ-013 SHALL have port ovf  output  1  registered flag, high when the last accepted bin_in exceeded 99_999_999.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and UPDATE.
REQ-015 In IDLE with bin_valid=1, on the clock edge (E0) the block SHALL:
- capture bin_in, dp_sel and dp_en;
- clear the 32-bit BCD accumulator and the iteration counter;
- enter SHIFT.
REQ-016 In IDLE with bin_valid=0, the block SHALL stay in IDLE and hold all outputs.
REQ-017 SHALL saturate any captured value above 99_999_999 to 99_999_999 and set the internal ovf flag; otherwise the internal ovf flag SHALL be cleared.
REQ-018 In SHIFT, each cycle SHALL perform one double-dabble iteration:
- add 3 to every BCD nibble that is >=5;
- then shift the {BCD, binary} register left by 1.
REQ-019 SHIFT SHALL last exactly 27 cycles (edges E1..E27) and then enter UPDATE.
REQ-020 In UPDATE, on edge E28 the block SHALL:
- register digit0..7, dp0..7 and ovf;
- assert done for exactly one cycle;
- return to IDLE.
REQ-021 Latency from the bin_valid sampling edge E0 to the output update edge E28 SHALL be 28 clocks.
REQ-022 busy SHALL be 1 in the SHIFT and UPDATE states and 0 in IDLE.
REQ-023 bin_valid while busy=1 SHALL be ignored; it SHALL not be queued and SHALL not affect the conversion in progress.
REQ-024 bin_valid asserted in the same cycle as done SHALL be accepted, because the FSM is already in IDLE.
REQ-025 dpN SHALL be 1 only when dp_en=1 and N equals dp_sel; all other dp outputs SHALL be 0.
REQ-026 When LZ_BLANK=1, digitK (K=7..1) SHALL be replaced by BLANK_CODE when all of the following hold:
- digits K..7 of the result are all 0;
- dp_en=0, or K > dp_sel.
REQ-027 digit0 SHALL never be blanked.
REQ-028 When LZ_BLANK=0, all 8 BCD digits SHALL be output unmodified.
REQ-029 Outputs SHALL change only at edge E28 (or on reset), so the downstream display never sees partial results.

Reset
REQ-030 While rst=1, outputs SHALL be:
- digit0..7=0, dp0..7=0;
- busy=0, done=0, ovf=0;
- FSM in IDLE, accumulator and counter cleared.
REQ-031 rst asserted mid-conversion SHALL abort the conversion immediately, with no done pulse and outputs at their reset values.
REQ-032 After rst deasserts, the first bin_valid SHALL start a fresh conversion with the normal 28-cycle latency.

Verification
REQ-033 bin_in=12_345_678, dp_en=0, single bin_valid pulse -> after 28 clocks digit7..0=1,2,3,4,5,6,7,8, dp all 0, done high exactly 1 cycle, busy high for 28 cycles, ovf=0.
REQ-034 bin_in=0, dp_en=0 -> digit0=0, digit7..1=4'hF.
REQ-035 bin_in=5, dp_en=1, dp_sel=3 -> digit3..0=0,0,0,5, digit7..4=4'hF, dp3=1, other dp=0.
REQ-036 bin_in=100_000_000 -> ovf=1, digit7..0 all 9.
REQ-037 Converting 42 with a second bin_valid carrying 7 at cycle 10 of the conversion -> outputs show 42 only (digit1=4, digit0=2), single done pulse; a new bin_valid on the done cycle starts a conversion that completes 28 clocks later.
REQ-038 rst pulsed at cycle 10 of a conversion of 99_999_999 -> digits=0, busy=0, ovf=0, no done pulse; a following conversion of 99_999_999 completes normally.
